// File: rtl/cherry_pkg.sv
// cherry_pkg: shared types and constants for the instruction queue path.
//   instr_type_t   - instruction class carried by every queue entry
//   queue_entry_t  - one FIFO entry as pushed by the control unit
//   clamp_copies() - maps a requested copy count onto 1..max_copies
package cherry_pkg;

    localparam int ADDR_WIDTH = 18;
    localparam int ARITH_W    = 14;
    localparam int RAM_W      = 9;
    localparam int LD_ST_W    = 10;
    // Wide enough for LOG_SUPERSCALAR_WIDTH+1 up to 8 bits.
    localparam int COPY_CNT_W = 8;

    typedef enum logic [1:0] {
        INSTR_TYPE_LOAD_STORE = 2'd0,
        INSTR_TYPE_RAM        = 2'd1,
        INSTR_TYPE_ARITHMETIC = 2'd2,
        INSTR_TYPE_LOOP       = 2'd3
    } instr_type_t;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_ISSUING = 1'b1
    } stage_state_t;

    typedef struct packed {
        instr_type_t             instr_type;
        logic [0:ARITH_W-1]      arith_instr;
        logic [0:RAM_W-1]        ram_instr;
        logic [0:LD_ST_W-1]      ld_st_instr;
        logic [ADDR_WIDTH-1:0]   cache_addr;
        logic [ADDR_WIDTH-1:0]   main_mem_addr;
        logic [ADDR_WIDTH-1:0]   d_cache_addr;
        logic [ADDR_WIDTH-1:0]   d_main_mem_addr;
        logic [COPY_CNT_W-1:0]   copy_count;   // already clamped to 1..SUPERSCALAR_WIDTH
    } queue_entry_t;

    // Zero means "one copy"; anything above the machine width saturates.
    function automatic logic [COPY_CNT_W-1:0] clamp_copies(
        input logic [COPY_CNT_W-1:0] req,
        input logic [COPY_CNT_W-1:0] max_copies
    );
        if (req == '0)
            return COPY_CNT_W'(1);
        if (req > max_copies)
            return max_copies;
        return req;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, depth 2^LOG_DEPTH, head visible on rd_data.
//   clk, reset (async active-low)
//   wr_en/wr_data  - push; ignored while full
//   rd_en/rd_data  - pop; rd_data is the current head (combinational read)
//   full, empty, count - occupancy derived from the registered count
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [LOG_DEPTH:0]   count
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic                 do_wr;
    logic                 do_rd;

    assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers are exactly LOG_DEPTH bits, so they wrap modulo depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (LOG_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_dispatcher.sv
// instruction_dispatcher: consumer end of the control-unit instruction queue.
// Buffers entries in a FIFO, expands each into copy_count superscalar copies
// (copy k at base + k*stride for both addresses) and issues one copy per
// cycle over valid/ready. LOOP entries are dequeued and dropped.
//   clk, reset (async active-low)
//   queue_*        - push side from the control unit
//   queue_full/empty, overflow_err - queue status (overflow is sticky)
//   issue_*        - current copy toward the execution front end
// Optional: define DISPATCH_PERF_COUNTERS_EN to add perf_issued/perf_stall.
module instruction_dispatcher
    import cherry_pkg::*;
#(
    parameter int LOG_SUPERSCALAR_WIDTH = 3,
    parameter int LOG_DEPTH             = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               queue_we,
    input  logic [1:0]                         queue_instr_type,
    input  logic [0:ARITH_W-1]                 queue_arith_instr,
    input  logic [0:RAM_W-1]                   queue_ram_instr,
    input  logic [0:LD_ST_W-1]                 queue_ld_st_instr,
    input  logic [ADDR_WIDTH-1:0]              cache_addr,
    input  logic [ADDR_WIDTH-1:0]              main_mem_addr,
    input  logic [ADDR_WIDTH-1:0]              d_cache_addr,
    input  logic [ADDR_WIDTH-1:0]              d_main_mem_addr,
    input  logic [LOG_SUPERSCALAR_WIDTH:0]     queue_copy_count,
    output logic                               queue_full,
    output logic                               queue_empty,
    output logic                               overflow_err,
    output logic                               issue_valid,
    input  logic                               issue_ready,
    output logic [1:0]                         issue_instr_type,
    output logic [0:ARITH_W-1]                 issue_arith_instr,
    output logic [0:RAM_W-1]                   issue_ram_instr,
    output logic [0:LD_ST_W-1]                 issue_ld_st_instr,
    output logic [ADDR_WIDTH-1:0]              issue_cache_addr,
    output logic [ADDR_WIDTH-1:0]              issue_main_mem_addr,
    output logic [LOG_SUPERSCALAR_WIDTH-1:0]   issue_copy_index,
    output logic                               issue_last
`ifdef DISPATCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]                        perf_issued,
    output logic [31:0]                        perf_stall
`endif
);

    localparam int SUPERSCALAR_WIDTH = 1 << LOG_SUPERSCALAR_WIDTH;
    localparam int DEPTH             = 1 << LOG_DEPTH;
    localparam int ENTRY_W           = $bits(queue_entry_t);
    localparam int KW                = LOG_SUPERSCALAR_WIDTH;

    queue_entry_t            push_entry;
    queue_entry_t            head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [LOG_DEPTH:0]      fifo_count;
    logic                    pop;
    logic                    load;
    logic                    advance;
    logic                    fire;
    logic                    at_last;
    logic                    head_is_real;
    stage_state_t            state_q;
    stage_state_t            state_d;
    logic [ADDR_WIDTH-1:0]   stage_d_cache;
    logic [ADDR_WIDTH-1:0]   stage_d_mem;
    logic [KW-1:0]           stage_last_k;

    // ---------------------------------------------------------------- push
    always_comb begin
        push_entry                 = '0;
        push_entry.instr_type      = instr_type_t'(queue_instr_type);
        push_entry.arith_instr     = queue_arith_instr;
        push_entry.ram_instr       = queue_ram_instr;
        push_entry.ld_st_instr     = queue_ld_st_instr;
        push_entry.cache_addr      = cache_addr;
        push_entry.main_mem_addr   = main_mem_addr;
        push_entry.d_cache_addr    = d_cache_addr;
        push_entry.d_main_mem_addr = d_main_mem_addr;
        push_entry.copy_count      = clamp_copies(COPY_CNT_W'(queue_copy_count),
                                                  COPY_CNT_W'(SUPERSCALAR_WIDTH));
    end

    sync_fifo #(
        .WIDTH     (ENTRY_W),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (queue_we),
        .wr_data (push_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign queue_full  = fifo_full;
    assign queue_empty = fifo_empty && (state_q == ST_EMPTY);

    // Judged on the registered occupancy: a pop in the same cycle does not
    // make room for a push that arrives while full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow_err <= 1'b0;
        else if (queue_we && (fifo_count == (LOG_DEPTH+1)'(DEPTH)))
            overflow_err <= 1'b1;
    end

    // ------------------------------------------------------- issue stage FSM
    assign fire         = (state_q == ST_ISSUING) && issue_ready;
    assign at_last      = (issue_copy_index == stage_last_k);
    assign head_is_real = (head.instr_type != INSTR_TYPE_LOOP);
    assign issue_last   = issue_valid && at_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    // A LOOP head is popped but not loaded, so the stage spends that cycle
    // (or falls back to) EMPTY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (!fifo_empty && head_is_real)
                    state_d = ST_ISSUING;
            end
            ST_ISSUING: begin
                if (fire && at_last)
                    state_d = (!fifo_empty && head_is_real) ? ST_ISSUING : ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        issue_valid = 1'b0;
        pop         = 1'b0;
        advance     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                pop = !fifo_empty;
            end
            ST_ISSUING: begin
                issue_valid = 1'b1;
                advance     = fire && !at_last;
                // Retiring the last copy refills from the head in the same
                // edge, so consecutive entries issue without a bubble.
                pop         = fire && at_last && !fifo_empty;
            end
            default: ;
        endcase
        load = pop && head_is_real;
    end

    // ------------------------------------------------------------ datapath
    // Copy addresses are accumulated stride by stride instead of k*stride.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_instr_type    <= '0;
            issue_arith_instr   <= '0;
            issue_ram_instr     <= '0;
            issue_ld_st_instr   <= '0;
            issue_cache_addr    <= '0;
            issue_main_mem_addr <= '0;
            issue_copy_index    <= '0;
            stage_d_cache       <= '0;
            stage_d_mem         <= '0;
            stage_last_k        <= '0;
        end else if (load) begin
            issue_instr_type    <= head.instr_type;
            issue_arith_instr   <= head.arith_instr;
            issue_ram_instr     <= head.ram_instr;
            issue_ld_st_instr   <= head.ld_st_instr;
            issue_cache_addr    <= head.cache_addr;
            issue_main_mem_addr <= head.main_mem_addr;
            issue_copy_index    <= '0;
            stage_d_cache       <= head.d_cache_addr;
            stage_d_mem         <= head.d_main_mem_addr;
            // Count is 1..SUPERSCALAR_WIDTH, so count-1 fits in KW bits.
            stage_last_k        <= KW'(head.copy_count - COPY_CNT_W'(1));
        end else if (advance) begin
            issue_copy_index    <= issue_copy_index + KW'(1);
            issue_cache_addr    <= issue_cache_addr + stage_d_cache;
            issue_main_mem_addr <= issue_main_mem_addr + stage_d_mem;
        end
    end

`ifdef DISPATCH_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (fire)
                perf_issued <= perf_issued + 32'd1;
            if (issue_valid && !issue_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed bench for instruction_dispatcher: expansion, back-pressure,
// back-to-back entries, full/overflow, LOOP discard, clamp, wrap, async reset.
module tb_instruction_dispatcher;
    import cherry_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        queue_we = 1'b0;
    logic [1:0]  queue_instr_type = '0;
    logic [0:13] queue_arith_instr = '0;
    logic [0:8]  queue_ram_instr = '0;
    logic [0:9]  queue_ld_st_instr = '0;
    logic [17:0] cache_addr = '0, main_mem_addr = '0, d_cache_addr = '0, d_main_mem_addr = '0;
    logic [3:0]  queue_copy_count = '0;
    logic        queue_full, queue_empty, overflow_err, issue_valid, issue_last;
    logic        issue_ready = 1'b0;
    logic [1:0]  issue_instr_type;
    logic [0:13] issue_arith_instr;
    logic [0:8]  issue_ram_instr;
    logic [0:9]  issue_ld_st_instr;
    logic [17:0] issue_cache_addr, issue_main_mem_addr;
    logic [2:0]  issue_copy_index;
`ifdef DISPATCH_PERF_COUNTERS_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    instruction_dispatcher dut (
        .clk(clk), .reset(reset), .queue_we(queue_we), .queue_instr_type(queue_instr_type),
        .queue_arith_instr(queue_arith_instr), .queue_ram_instr(queue_ram_instr),
        .queue_ld_st_instr(queue_ld_st_instr), .cache_addr(cache_addr),
        .main_mem_addr(main_mem_addr), .d_cache_addr(d_cache_addr),
        .d_main_mem_addr(d_main_mem_addr), .queue_copy_count(queue_copy_count),
        .queue_full(queue_full), .queue_empty(queue_empty), .overflow_err(overflow_err),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr_type(issue_instr_type), .issue_arith_instr(issue_arith_instr),
        .issue_ram_instr(issue_ram_instr), .issue_ld_st_instr(issue_ld_st_instr),
        .issue_cache_addr(issue_cache_addr), .issue_main_mem_addr(issue_main_mem_addr),
        .issue_copy_index(issue_copy_index), .issue_last(issue_last)
`ifdef DISPATCH_PERF_COUNTERS_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [41:0] q_obs[$];
    logic [41:0] q_exp[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] rec(input logic [1:0] t, input logic [17:0] c,
                                        input logic [17:0] m, input logic [2:0] k,
                                        input logic l);
        return {t, c, m, k, l};
    endfunction

    // Every handshake, recorded mid-cycle.
    always @(negedge clk)
        if (reset && issue_valid && issue_ready)
            q_obs.push_back(rec(issue_instr_type, issue_cache_addr, issue_main_mem_addr,
                                issue_copy_index, issue_last));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [3:0] cnt, input logic [17:0] c,
                        input logic [17:0] dc, input logic [17:0] m, input logic [17:0] dm);
        queue_we          = 1'b1;
        queue_instr_type  = t;
        queue_copy_count  = cnt;
        cache_addr        = c;
        d_cache_addr      = dc;
        main_mem_addr     = m;
        d_main_mem_addr   = dm;
        queue_arith_instr = c[13:0];
        queue_ram_instr   = c[8:0];
        queue_ld_st_instr = c[9:0];
        step();
        queue_we = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !issue_valid; i++)
            step();
        chk("wait_valid", issue_valid, 1);
    endtask

    task automatic drain(input string tag, input int cycles);
        int n;
        issue_ready = 1'b1;
        repeat (cycles) step();
        chk({tag, "_n"}, q_obs.size(), q_exp.size());
        n = (q_obs.size() < q_exp.size()) ? q_obs.size() : q_exp.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_%0d", tag, i), q_obs[i], q_exp[i]);
        q_obs.delete();
        q_exp.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state
        step(); step();
        chk("rst_empty", queue_empty, 1);
        chk("rst_full", queue_full, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_valid", issue_valid, 0);
        chk("rst_last", issue_last, 0);
        chk("rst_cache", issue_cache_addr, 0);
        chk("rst_k", issue_copy_index, 0);
        reset = 1'b1;
        step();

        // ---- expansion and latency
        issue_ready = 1'b1;
        push(2'd1, 4'd3, 18'd100, 18'd4, 18'd1000, 18'd16);
        chk("lat_edge1", issue_valid, 0);
        step();
        chk("lat_edge2", issue_valid, 1);
        chk("exp_k0_cache", issue_cache_addr, 100);
        chk("exp_k0_mem", issue_main_mem_addr, 1000);
        chk("exp_k0_last", issue_last, 0);
        chk("exp_ram_pl", issue_ram_instr, 100);
        step(); step();
        chk("exp_k2_last", issue_last, 1);
        chk("exp_k2_cache", issue_cache_addr, 108);
        chk("exp_k2_ram_pl", issue_ram_instr, 100);
        step();
        chk("exp_done_valid", issue_valid, 0);
        chk("exp_done_empty", queue_empty, 1);
        q_exp.push_back(rec(2'd1, 18'd100, 18'd1000, 3'd0, 1'b0));
        q_exp.push_back(rec(2'd1, 18'd104, 18'd1016, 3'd1, 1'b0));
        q_exp.push_back(rec(2'd1, 18'd108, 18'd1032, 3'd2, 1'b1));
        drain("exp", 4);

        // ---- back-pressure frozen at k=1
        push(2'd1, 4'd3, 18'd200, 18'd8, 18'd0, 18'd1);
        wait_valid();
        step();
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_k_%0d", i), issue_copy_index, 1);
            chk($sformatf("bp_cache_%0d", i), issue_cache_addr, 208);
            chk($sformatf("bp_valid_%0d", i), issue_valid, 1);
        end
        q_exp.push_back(rec(2'd1, 18'd200, 18'd0, 3'd0, 1'b0));
        q_exp.push_back(rec(2'd1, 18'd208, 18'd1, 3'd1, 1'b0));
        q_exp.push_back(rec(2'd1, 18'd216, 18'd2, 3'd2, 1'b1));
        drain("bp", 6);

        // ---- back-to-back entries, no bubble
        issue_ready = 1'b0;
        push(2'd2, 4'd2, 18'd0, 18'd1, 18'd10, 18'd1);
        push(2'd0, 4'd2, 18'd50, 18'd2, 18'd60, 18'd2);
        step(); step();
        issue_ready = 1'b1;
        chk("b2b_v0", issue_valid, 1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("b2b_v%0d", i), issue_valid, 1);
        end
        step();
        chk("b2b_v4", issue_valid, 0);
        q_exp.push_back(rec(2'd2, 18'd0, 18'd10, 3'd0, 1'b0));
        q_exp.push_back(rec(2'd2, 18'd1, 18'd11, 3'd1, 1'b1));
        q_exp.push_back(rec(2'd0, 18'd50, 18'd60, 3'd0, 1'b0));
        q_exp.push_back(rec(2'd0, 18'd52, 18'd62, 3'd1, 1'b1));
        drain("b2b", 2);

        // ---- full / overflow: stage holds a blocker, then 17 pushes
        issue_ready = 1'b0;
        push(2'd1, 4'd1, 18'd500, 18'd0, 18'd0, 18'd0);
        step();
        chk("ful_blocker", issue_cache_addr, 500);
        for (int i = 0; i < 17; i++) begin
            push(2'd0, 4'd1, 18'(i + 1), 18'd0, 18'(i + 1), 18'd0);
            if (i == 14) chk("ful_15_notfull", queue_full, 0);
            if (i == 15) begin
                chk("ful_16_full", queue_full, 1);
                chk("ful_16_noovf", overflow_err, 0);
            end
            if (i == 16) begin
                chk("ful_17_ovf", overflow_err, 1);
                chk("ful_17_full", queue_full, 1);
            end
        end
        q_exp.push_back(rec(2'd1, 18'd500, 18'd0, 3'd0, 1'b1));
        for (int i = 0; i < 16; i++)
            q_exp.push_back(rec(2'd0, 18'(i + 1), 18'(i + 1), 3'd0, 1'b1));
        drain("ful", 25);
        chk("ful_drained", queue_empty, 1);
        chk("ful_ovf_sticky", overflow_err, 1);

        // ---- count 0, LOOP discard, address wrap, clamp of 15 to 8
        issue_ready = 1'b1;
        push(2'd2, 4'd0, 18'h3FFFF, 18'd1, 18'd5, 18'd0);
        push(2'd3, 4'd2, 18'd77, 18'd1, 18'd77, 18'd1);
        push(2'd1, 4'd2, 18'h3FFFF, 18'd1, 18'h3FFFE, 18'd3);
        push(2'd0, 4'd15, 18'd0, 18'd1, 18'd0, 18'd2);
        q_exp.push_back(rec(2'd2, 18'h3FFFF, 18'd5, 3'd0, 1'b1));
        q_exp.push_back(rec(2'd1, 18'h3FFFF, 18'h3FFFE, 3'd0, 1'b0));
        q_exp.push_back(rec(2'd1, 18'h00000, 18'h00001, 3'd1, 1'b1));
        for (int k = 0; k < 8; k++)
            q_exp.push_back(rec(2'd0, 18'(k), 18'(2 * k), 3'(k), k == 7));
        drain("wrp", 30);

        // ---- async reset mid-issue
        issue_ready = 1'b0;
        push(2'd0, 4'd4, 18'd9, 18'd1, 18'd9, 18'd1);
        push(2'd1, 4'd2, 18'd33, 18'd1, 18'd33, 18'd1);
        wait_valid();
        #3;
        reset = 1'b0;
        #1;
        chk("arst_valid", issue_valid, 0);
        chk("arst_empty", queue_empty, 1);
        chk("arst_full", queue_full, 0);
        chk("arst_ovf", overflow_err, 0);
        chk("arst_cache", issue_cache_addr, 0);
        step();
        reset = 1'b1;
        issue_ready = 1'b1;
        step(); step(); step();
        chk("arst_post_valid", issue_valid, 0);
        chk("arst_post_empty", queue_empty, 1);
        chk("arst_no_issue", q_obs.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
